// File: rtl/ps2_pkg.sv
// Shared PS/2 command constants and the LED command sequencer state encoding.
// Pure definitions, no logic; no latency.
// No flow control of its own.
package ps2_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_TX1,
    ST_WAIT_ACK1,
    ST_SEND_ARG,
    ST_WAIT_TX2,
    ST_WAIT_ACK2
  } seq_state_t;

  // True for the two keyboard replies the sequencer consumes.
  function automatic logic is_kbd_reply(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// Saturating reply-wait counter with clear, load and enable; flags expiry at LIMIT.
// Count updates one cycle after clr/load/en; expired is combinational from the count.
// No backpressure: the count holds at LIMIT and never wraps.
module ps2_ack_timer #(
  parameter int LIMIT = 1_000_000,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count;

  // Clear has priority over load; loads above LIMIT are clamped; counting stops at LIMIT.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (load)
      count <= (load_val > LIMIT_W) ? LIMIT_W : load_val;
    else if (en && (count != LIMIT_W))
      count <= count + 1'b1;
  end

  assign expired = (count == LIMIT_W);

endmodule

// File: rtl/ps2_cmd_seq.sv
// Sends Set-LEDs (0xED) plus argument to the keyboard, with retry on RESEND/timeout/tx_err.
// tx_start one cycle after SEND state sees tx_ready; rx pass-through has 1-cycle latency.
// Waits on tx_ready before every start; one led_req is queued while a sequence runs.
module ps2_cmd_seq
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_pass_valid,
  output logic [7:0] rx_pass_byte,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] led_state
);

  localparam int              RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);
  localparam int              TW        = $clog2(ACK_TIMEOUT + 1);

  seq_state_t    state, state_nxt, retry_to;
  logic [2:0]    arg, arg_nxt;
  logic          pend, pend_nxt;
  logic [2:0]    pend_val, pend_val_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic          tx_start_nxt, done_nxt, fail_nxt;
  logic [7:0]    tx_byte_nxt;
  logic [2:0]    led_nxt;
  logic          tmr_clr, tmr_en, tmr_expired, retry_take;
  logic          in_ack_wait, consume;

  ps2_ack_timer #(.LIMIT(ACK_TIMEOUT), .W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ({TW{1'b0}}),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  // State and all sequencer registers; reset drops any queued request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      arg       <= 3'b000;
      pend      <= 1'b0;
      pend_val  <= 3'b000;
      retry_cnt <= '0;
      tx_start  <= 1'b0;
      tx_byte   <= 8'h00;
      done      <= 1'b0;
      fail      <= 1'b0;
      led_state <= 3'b000;
    end else begin
      state     <= state_nxt;
      arg       <= arg_nxt;
      pend      <= pend_nxt;
      pend_val  <= pend_val_nxt;
      retry_cnt <= retry_nxt;
      tx_start  <= tx_start_nxt;
      tx_byte   <= tx_byte_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
      led_state <= led_nxt;
    end
  end

  // Next-state logic; every retry source funnels through one retry/fail decision at the end.
  always_comb begin
    state_nxt    = state;
    arg_nxt      = arg;
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    retry_nxt    = retry_cnt;
    tx_start_nxt = 1'b0;
    tx_byte_nxt  = tx_byte;
    done_nxt     = 1'b0;
    fail_nxt     = 1'b0;
    led_nxt      = led_state;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    retry_take   = 1'b0;
    retry_to     = state;

    // Requests outside IDLE (including the done/fail cycle) overwrite the single queue slot.
    if (led_req && (state != ST_IDLE)) begin
      pend_nxt     = 1'b1;
      pend_val_nxt = led_val;
    end

    case (state)
      ST_IDLE: begin
        if (led_req || pend) begin
          arg_nxt   = led_req ? led_val : pend_val;
          pend_nxt  = 1'b0;
          retry_nxt = '0;
          state_nxt = ST_SEND_CMD;
        end
      end
      ST_SEND_CMD: begin
        if (tx_ready) begin
          tx_start_nxt = 1'b1;
          tx_byte_nxt  = PS2_CMD_SET_LED;
          state_nxt    = ST_WAIT_TX1;
        end
      end
      ST_SEND_ARG: begin
        if (tx_ready) begin
          tx_start_nxt = 1'b1;
          tx_byte_nxt  = {5'b00000, arg};
          state_nxt    = ST_WAIT_TX2;
        end
      end
      ST_WAIT_TX1, ST_WAIT_TX2: begin
        if (tx_err) begin
          retry_take = 1'b1;
          retry_to   = (state == ST_WAIT_TX1) ? ST_SEND_CMD : ST_SEND_ARG;
        end else if (tx_done) begin
          tmr_clr   = 1'b1;
          state_nxt = (state == ST_WAIT_TX1) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
        end
      end
      ST_WAIT_ACK1, ST_WAIT_ACK2: begin
        tmr_en   = 1'b1;
        retry_to = (state == ST_WAIT_ACK1) ? ST_SEND_CMD : ST_SEND_ARG;
        // Any received byte masks a coincident timeout for this cycle.
        if (rx_valid) begin
          if (rx_byte == PS2_ACK) begin
            retry_nxt = '0;
            if (state == ST_WAIT_ACK1) begin
              state_nxt = ST_SEND_ARG;
            end else begin
              led_nxt   = arg;
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else if (rx_byte == PS2_RESEND) begin
            retry_take = 1'b1;
          end
        end else if (tmr_expired) begin
          retry_take = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (retry_take) begin
      if (retry_cnt == RETRY_MAX) begin
        fail_nxt  = 1'b1;
        retry_nxt = '0;
        state_nxt = ST_IDLE;
      end else begin
        retry_nxt = retry_cnt + 1'b1;
        state_nxt = retry_to;
      end
    end
  end

  assign busy        = (state != ST_IDLE);
  assign in_ack_wait = (state == ST_WAIT_ACK1) || (state == ST_WAIT_ACK2);
  assign consume     = in_ack_wait && is_kbd_reply(rx_byte);

  // Forward everything except ACK/RESEND that answer our own command.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pass_valid <= 1'b0;
      rx_pass_byte  <= 8'h00;
    end else begin
      rx_pass_valid <= rx_valid && !consume;
      if (rx_valid && !consume)
        rx_pass_byte <= rx_byte;
    end
  end

endmodule

// File: doc/ps2_cmd_seq.md
Name: ps2_cmd_seq

Overview:
Host-to-keyboard command sequencer for the PS/2 port.
- On request, sends the Set-LEDs command (0xED) followed by the LED argument byte to the keyboard, through a shared PS/2 transmit engine.
- Consumes the keyboard's ACK (0xFA) and RESEND (0xFE) replies. All other received bytes (scan codes) are forwarded to the scan/UART/display path.
- Sits between the PS/2 line engines and the existing scan-code consumers.

Parameters:
- ACK_TIMEOUT, 1_000_000, clock cycles to wait for an ACK/RESEND after a frame completes (20 ms at 50 MHz).
- MAX_RETRY, 3, retransmissions allowed per byte before the sequence fails.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- led_req  in  1  one-cycle request to apply led_val.
- led_val  in  3  {caps, num, scroll}.
- tx_ready  in  1  TX engine idle; can accept a byte.
- tx_start  out  1  one-cycle pulse; TX engine latches tx_byte.
- tx_byte  out  8  byte for the TX engine.
- tx_done  in  1  pulse; frame sent and line-level ACK bit seen.
- tx_err  in  1  pulse; frame aborted (no line-level ACK, clock stuck).
- rx_valid  in  1  pulse; rx_byte valid from the PS/2 receiver.
- rx_byte  in  8  received byte.
- rx_pass_valid  out  1  pulse; forwarded byte valid.
- rx_pass_byte  out  8  forwarded byte.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse; sequence succeeded.
- fail  out  1  one-cycle pulse; sequence abandoned.
- led_state  out  3  last value the keyboard acknowledged.

Behaviour:
Reset values:
- All pulses 0; busy 0; tx_byte 0x00; rx_pass_byte 0x00; led_state 3'b000.
- FSM in IDLE; pending flag clear; retry count 0; timer 0.

States and transitions:
- IDLE: on led_req (or pending flag set), latch arg = {5'b0, led_val}, clear pending, go to SEND_CMD. busy goes 1 the cycle after the request.
- SEND_CMD: tx_byte = 0xED. Pulse tx_start in the first cycle tx_ready = 1, then go to WAIT_TX1.
- WAIT_TX1:
  - tx_done: clear timer, go to WAIT_ACK1.
  - tx_err: counts as one retry; resend via SEND_CMD.
- WAIT_ACK1:
  - rx 0xFA: go to SEND_ARG; reset retry count.
  - rx 0xFE: retry; go to SEND_CMD.
  - Timer reaches ACK_TIMEOUT: retry; go to SEND_CMD.
- SEND_ARG / WAIT_TX2 / WAIT_ACK2: same rules, with tx_byte = arg and retries returning to SEND_ARG.
  - On 0xFA in WAIT_ACK2: led_state <= arg[2:0], pulse done, go to IDLE.
- Retry rule: a retry taken when the retry count already equals MAX_RETRY instead pulses fail and returns to IDLE. led_state is unchanged and the retry count is cleared.

Timing:
- tx_start, done and fail are single-cycle registered pulses.
- tx_start must not assert while tx_ready = 0.
- Timer is $clog2(ACK_TIMEOUT+1) bits. It saturates and never wraps.

Rx pass-through:
- Registered, 1-cycle latency: rx_pass_byte <= rx_byte and rx_pass_valid <= 1 on the cycle after rx_valid.
- Applies to every byte except 0xFA/0xFE received while in WAIT_ACK1/WAIT_ACK2, which are consumed.
- 0xFA/0xFE received in any other state are forwarded, not consumed.

Simultaneous events:
- rx_valid and timer expiry in the same cycle: the received byte takes priority and the timeout is ignored.
- tx_done and tx_err in the same cycle: tx_err wins.
- led_req while busy: set pending and overwrite the latched next value with the latest led_val (single-deep queue). It is serviced from IDLE the cycle after done/fail.
- led_req in the same cycle as done/fail: treated as pending.

Reset mid-operation: returns to IDLE immediately and drops pending. The TX engine is reset by the same rst.

Decomposition:
- Shared package ps2_pkg: constants PS2_CMD_SET_LED = 0xED, PS2_ACK = 0xFA, PS2_RESEND = 0xFE, plus the FSM state enum.
- One natural sub-module: ps2_ack_timer, a loadable saturating counter with clear/enable and an expired flag.

Test Plan:
1. led_req with led_val = 3'b101; model replies 0xFA after each tx_done → tx_byte 0xED then 0x05, done pulse, led_state = 3'b101, busy low after done.
2. First reply 0xFE, then 0xFA → 0xED transmitted twice, then 0x05, done, led_state updated; retry count resets for the argument byte.
3. No reply, ACK_TIMEOUT = 100 → 0xED transmitted 4 times (1 + MAX_RETRY), fail pulse about 100 cycles after the 4th tx_done, led_state unchanged, no done.
4. Scan code 0x1C arriving in WAIT_ACK1, followed by 0xFA → rx_pass_valid with 0x1C one cycle later; 0xFA not forwarded; sequence continues. 0xFA arriving in IDLE is forwarded.
5. led_req 3'b001 while busy, then led_req 3'b110 while still busy → after the first done, a second sequence sends 0xED then 0x06 only; final led_state = 3'b110.
6. rst asserted during WAIT_TX2 → next cycle busy = 0, no pulses; later 0xFA forwarded; fresh led_req starts cleanly with 0xED.
